// File: rtl/clk_div_sched.sv
// Run-time controller for a divide-by-N clock: clean start/stop and ratio changes
// that only take effect on a period boundary, so clk_out never shows a runt pulse.
module clk_div_sched #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEF_DIV = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] cur_div
);

  localparam int unsigned HW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_err_q, cfg_err_d;

  logic             xfer_c;
  logic             legal_c;
  logic             wrap_c;
  logic [HW-1:0]    high_len_c;

  assign xfer_c  = cfg_valid && cfg_ready_q;
  assign legal_c = (cfg_div >= WIDTH'(2));
  assign wrap_c  = (count_q == WIDTH'(cur_div_q - WIDTH'(1)));

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      cur_div_q   <= WIDTH'(DEF_DIV);
      pend_div_q  <= '0;
      pend_q      <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cur_div_q   <= cur_div_d;
      pend_div_q  <= pend_div_d;
      pend_q      <= pend_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Next-state, counter, ratio handshake and next output values.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    cur_div_d   = cur_div_q;
    pend_div_d  = pend_div_q;
    pend_d      = pend_q;
    cfg_err_d   = 1'b0;
    busy_d      = 1'b0;
    clk_out_d   = 1'b0;
    tick_d      = 1'b0;
    cfg_ready_d = 1'b1;
    high_len_c  = '0;

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        // While stopped a legal ratio is applied directly, never left pending.
        if (xfer_c) begin
          if (legal_c) cur_div_d = cfg_div;
          else         cfg_err_d = 1'b1;
        end
        if (en) state_d = RUN;
      end

      RUN, DRAIN: begin
        if (wrap_c) begin
          count_d = '0;
          if (pend_q) begin
            cur_div_d = pend_div_q;
            pend_d    = 1'b0;
          end
        end else begin
          count_d = WIDTH'(count_q + WIDTH'(1));
        end
        // A transfer needs pend_q==0, so it never collides with applying a ratio.
        if (xfer_c) begin
          if (legal_c) begin
            pend_d     = 1'b1;
            pend_div_d = cfg_div;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (en)                    state_d = RUN;
        else if (state_q == RUN)   state_d = DRAIN;
        else if (wrap_c)           state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    busy_d      = (state_d != IDLE);
    high_len_c  = HW'((HW'(cur_div_d) + HW'(1)) >> 1);
    clk_out_d   = busy_d && (HW'(count_d) < high_len_c);
    tick_d      = busy_d && (count_d == '0);
    cfg_ready_d = !pend_d;
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed and random stimulus for clk_div_sched, checked every cycle against a
// period-level reference model (position in period, ratio, queue of pending ratios).
module tb_clk_div_sched;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned DEF_DIV = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [WIDTH-1:0] cur_div;

  clk_div_sched #(.WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: running/stopping flags, position within the period, ratio in force.
  bit running, stopping, m_err;
  int pos, ratio;
  int pq[$];

  function automatic void model_reset();
    running = 0; stopping = 0; m_err = 0;
    pos = 0; ratio = DEF_DIV;
    pq.delete();
  endfunction

  function automatic void model_step(bit e, bit v, int d);
    bit took, last;
    took  = v && (pq.size() == 0);
    m_err = took && (d < 2);
    if (!running) begin
      if (took && d >= 2) ratio = d;
      pos = 0;
      if (e) begin running = 1; stopping = 0; end
    end else begin
      last = (pos == ratio - 1);
      if (last && pq.size() != 0) ratio = pq.pop_front();
      pos = last ? 0 : pos + 1;
      if (took && d >= 2) pq.push_back(d);
      if (e)             stopping = 0;
      else if (!stopping) stopping = 1;
      else if (last) begin running = 0; stopping = 0; pos = 0; end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("clk_out",   32'(clk_out),   32'(running && pos < (ratio + 1) / 2));
    chk("tick",      32'(tick),      32'(running && pos == 0));
    chk("busy",      32'(busy),      32'(running));
    chk("cur_div",   32'(cur_div),   32'(ratio));
    chk("cfg_ready", 32'(cfg_ready), 32'(pq.size() == 0));
    chk("cfg_err",   32'(cfg_err),   32'(m_err));
  endtask

  task automatic cycle(input bit e, input bit v, input int d);
    en = e; cfg_valid = v; cfg_div = WIDTH'(d);
    @(posedge clk);
    model_step(e, v, d);
    #1;
    check_all();
  endtask

  task automatic run_until_pos(input int p, input bit e);
    int n = 0;
    while (!(running && pos == p) && n < 40) begin cycle(e, 0, 0); n++; end
    chk("wait_pos", 32'(running && pos == p), 32'd1);
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    model_reset();
    #12 check_all();
    @(negedge clk);
    reset = 1'b1;

    // Default ratio 6: 1,1,1,0,0,0 with a tick every sixth cycle.
    repeat (14) cycle(1, 0, 0);

    // Mid-period ratio change to 5 waits for the wrap.
    run_until_pos(2, 1);
    cycle(1, 1, 5);
    repeat (14) cycle(1, 0, 0);

    // Illegal ratios 1 and 0 pulse cfg_err and change nothing.
    cycle(1, 1, 1);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    repeat (3) cycle(1, 0, 0);

    // Back to 6, then stop at count 1 and drain to IDLE.
    cycle(1, 1, 6);
    repeat (8) cycle(1, 0, 0);
    run_until_pos(1, 1);
    repeat (8) cycle(0, 0, 0);
    // Stop, then resume during DRAIN without a gap.
    repeat (3) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);
    repeat (8) cycle(1, 0, 0);
    repeat (10) cycle(0, 0, 0);

    // Ratio 3 offered in IDLE together with en rising.
    cycle(1, 1, 3);
    repeat (9) cycle(1, 0, 0);

    // Transfer landing exactly on a wrap is deferred one period.
    run_until_pos(2, 1);
    cycle(1, 1, 7);
    repeat (12) cycle(1, 0, 0);

    // Async reset at count 2 with a ratio pending.
    run_until_pos(1, 1);
    cycle(1, 1, 9);
    async_reset();
    repeat (4) cycle(1, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else cycle($urandom_range(0, 9) > 2, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
